// File: rtl/gem_ext_fifo_rx.sv
// GEM RX external-FIFO write port to 8-bit AXI-Stream, store-and-forward.
// Whole frames are committed at eop; partial, flushed or overflowed frames roll back.
module gem_ext_fifo_rx #(
  parameter int DEPTH          = 2048,
  parameter bit DROP_BAD_FRAME = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] gem_rx_w_data,
  input  logic       gem_rx_w_wr,
  input  logic       gem_rx_w_sop,
  input  logic       gem_rx_w_eop,
  input  logic       gem_rx_w_err,
  input  logic       gem_rx_w_flush,
  output logic       gem_rx_w_overflow,
  input  logic       gem_dma_rx_end_tog,
  output logic       gem_dma_rx_status_tog,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser,
  output logic       status_good_frame,
  output logic       status_bad_frame,
  output logic       status_overflow
);

  localparam int AW = $clog2(DEPTH);

  typedef logic [AW:0] ptr_t;
  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_DROP
  } state_t;

  localparam ptr_t DEPTH_P = ptr_t'(DEPTH);
  localparam ptr_t ONE     = ptr_t'(1);

  logic [9:0] mem [DEPTH];

  state_t     st_q, st_d;
  ptr_t       wr_ptr_q, wr_ptr_d;
  ptr_t       commit_q, commit_d;
  ptr_t       rd_ptr_q, rd_ptr_d;
  ptr_t       base;
  logic       store;
  logic       mem_we;
  logic [9:0] mem_wdata;

  logic       good_q, good_d;
  logic       bad_q, bad_d;
  logic       ovf_q, ovf_d;
  logic       full_out_q, full_out_d;

  logic       s1_valid_q, s1_valid_d;
  logic [9:0] s1_word_q;
  logic       tvalid_q, tvalid_d;
  logic [9:0] out_word_q, out_word_d;
  logic       out_ready;
  logic       s1_free;
  logic       rd_en;

  logic       end_tog_q;
  logic       edge_q, edge_d;
  logic       stat_tog_q, stat_tog_d;

  assign mem_wdata = {gem_rx_w_err & gem_rx_w_eop, gem_rx_w_eop, gem_rx_w_data};

  always_comb begin
    st_d     = st_q;
    wr_ptr_d = wr_ptr_q;
    commit_d = commit_q;
    base     = wr_ptr_q;
    store    = 1'b0;
    mem_we   = 1'b0;
    good_d   = 1'b0;
    bad_d    = 1'b0;
    ovf_d    = 1'b0;
    if (gem_rx_w_flush && st_q != S_IDLE) begin
      wr_ptr_d = commit_q;
      st_d     = S_IDLE;
      ovf_d    = (st_q == S_DROP);
    end else if (gem_rx_w_wr) begin
      unique case (st_q)
        S_IDLE: begin
          store = gem_rx_w_sop;
          base  = commit_q;
        end
        S_WRITE: begin
          store = 1'b1;
          // sop without a preceding eop restarts the frame
          base  = gem_rx_w_sop ? commit_q : wr_ptr_q;
        end
        default: begin
          if (gem_rx_w_eop) begin
            wr_ptr_d = commit_q;
            st_d     = S_IDLE;
            ovf_d    = 1'b1;
          end
        end
      endcase
      if (store) begin
        if ((base - rd_ptr_q) == DEPTH_P) begin
          wr_ptr_d = commit_q;
          st_d     = gem_rx_w_eop ? S_IDLE : S_DROP;
          ovf_d    = gem_rx_w_eop;
        end else begin
          mem_we = 1'b1;
          if (!gem_rx_w_eop) begin
            wr_ptr_d = base + ONE;
            st_d     = S_WRITE;
          end else begin
            st_d   = S_IDLE;
            good_d = !gem_rx_w_err;
            bad_d  = gem_rx_w_err;
            if (gem_rx_w_err && DROP_BAD_FRAME) begin
              wr_ptr_d = commit_q;
            end else begin
              wr_ptr_d = base + ONE;
              commit_d = base + ONE;
            end
          end
        end
      end
    end
  end

  // two-stage read: registered RAM read, then the AXIS output register
  always_comb begin
    out_ready  = !tvalid_q || m_axis_tready;
    s1_free    = !s1_valid_q || out_ready;
    rd_en      = (rd_ptr_q != commit_q) && s1_free;
    rd_ptr_d   = rd_en ? rd_ptr_q + ONE : rd_ptr_q;
    s1_valid_d = rd_en || (s1_valid_q && !out_ready);
    tvalid_d   = tvalid_q;
    out_word_d = out_word_q;
    if (out_ready) begin
      tvalid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_word_d = s1_word_q;
      end
    end
  end

  always_comb begin
    full_out_d = ((wr_ptr_d - rd_ptr_d) == DEPTH_P) || (st_d == S_DROP);
    edge_d     = gem_dma_rx_end_tog ^ end_tog_q;
    stat_tog_d = stat_tog_q ^ edge_q;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[base[AW-1:0]] <= mem_wdata;
    end
    if (rd_en) begin
      s1_word_q <= mem[rd_ptr_q[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= S_IDLE;
      wr_ptr_q   <= '0;
      commit_q   <= '0;
      rd_ptr_q   <= '0;
      good_q     <= 1'b0;
      bad_q      <= 1'b0;
      ovf_q      <= 1'b0;
      full_out_q <= 1'b0;
      s1_valid_q <= 1'b0;
      tvalid_q   <= 1'b0;
      out_word_q <= '0;
      end_tog_q  <= gem_dma_rx_end_tog;
      edge_q     <= 1'b0;
      stat_tog_q <= 1'b0;
    end else begin
      st_q       <= st_d;
      wr_ptr_q   <= wr_ptr_d;
      commit_q   <= commit_d;
      rd_ptr_q   <= rd_ptr_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
      ovf_q      <= ovf_d;
      full_out_q <= full_out_d;
      s1_valid_q <= s1_valid_d;
      tvalid_q   <= tvalid_d;
      out_word_q <= out_word_d;
      end_tog_q  <= gem_dma_rx_end_tog;
      edge_q     <= edge_d;
      stat_tog_q <= stat_tog_d;
    end
  end

  assign gem_rx_w_overflow     = full_out_q;
  assign gem_dma_rx_status_tog = stat_tog_q;
  assign m_axis_tvalid         = tvalid_q;
  assign m_axis_tdata          = out_word_q[7:0];
  assign m_axis_tlast          = out_word_q[8];
  assign m_axis_tuser          = out_word_q[9];
  assign status_good_frame     = good_q;
  assign status_bad_frame      = bad_q;
  assign status_overflow       = ovf_q;

endmodule
